// File: rtl/viterbi_bmu_param.sv
// Branch-metric unit for a rate-1/2 convolutional Viterbi decoder: one metric per trellis branch.
// Latency 1 cycle from input transfer to out_valid; full throughput while out_ready stays high.
// Backpressure: the output bundle holds until out_ready; in_ready drops while it is stalled or on refresh.
//
// Ports:
//   clk, rst (async, active-high), refresh (sync frame restart)
//   in_valid / in_ready / in_sym    : received code pair ({c0,c1} hard, {r0,r1} soft)
//   out_valid / out_ready           : output bundle handshake
//   out_bm                          : branch j = {state, bit} metric at [j*BMW +: BMW]
//   out_reach                       : bit s set when state s is reachable at this symbol
//   out_first / out_last            : symbol 0 / symbol FRAME_LEN-1 of a frame
// Build option: define VITERBI_BMU_SOFT_EN for soft-decision input (IW = 2*SOFT_W, BMW = SOFT_W+1).
module viterbi_bmu_param #(
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101,
   parameter int             FRAME_LEN = 16,
   parameter int             SOFT_W    = 3,
   localparam int            NS        = 1 << (K - 1),
   localparam int            NB        = 1 << K,
`ifdef VITERBI_BMU_SOFT_EN
   localparam int            IW        = 2 * SOFT_W,
   localparam int            BMW       = SOFT_W + 1,
`else
   localparam int            IW        = 2,
   localparam int            BMW       = 2,
`endif
   localparam int            CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              refresh,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IW-1:0]     in_sym,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NB*BMW-1:0] out_bm,
   output logic [NS-1:0]     out_reach,
   output logic              out_first,
   output logic              out_last
);

   logic              xfer;
   logic [CW-1:0]     sym_cnt;
   logic [NB*BMW-1:0] bm_next;
   logic [NS-1:0]     reach_next;
   logic              cnt_is_last;

   assign in_ready    = !refresh && (!out_valid || out_ready);
   assign xfer        = in_valid && in_ready;
   assign cnt_is_last = (sym_cnt == CW'(FRAME_LEN - 1));

   // Branch metrics. Branch index j = {s, b}; the encoder register for that branch
   // is {b, s}, i.e. the input bit enters at the top (newest) position.
   always_comb begin
      logic [K-1:0] jv;
      logic [K-1:0] r;
      logic         e0;
      logic         e1;
`ifdef VITERBI_BMU_SOFT_EN
      logic [SOFT_W-1:0] r0;
      logic [SOFT_W-1:0] r1;
      logic [SOFT_W-1:0] d0;
      logic [SOFT_W-1:0] d1;
`else
      logic c0;
      logic c1;
`endif
      bm_next = '0;
      jv      = '0;
      r       = '0;
      e0      = 1'b0;
      e1      = 1'b0;
`ifdef VITERBI_BMU_SOFT_EN
      r0 = in_sym[IW-1:SOFT_W];
      r1 = in_sym[SOFT_W-1:0];
      d0 = '0;
      d1 = '0;
`else
      c0 = in_sym[1];
      c1 = in_sym[0];
`endif
      for (int j = 0; j < NB; j++) begin
         jv = K'(j);
         r  = {jv[0], jv[K-1:1]};
         e0 = ^(r & G0);
         e1 = ^(r & G1);
`ifdef VITERBI_BMU_SOFT_EN
         // Distance to M = 2^SOFT_W-1 is M - r, which for an all-ones M is just ~r.
         d0 = e0 ? ~r0 : r0;
         d1 = e1 ? ~r1 : r1;
         bm_next[j*BMW +: BMW] = BMW'(d0) + BMW'(d1);
`else
         bm_next[j*BMW +: BMW] = BMW'(c0 ^ e0) + BMW'(c1 ^ e1);
`endif
      end
   end

   // Warm-up mask: starting from state 0, after t symbols only states whose
   // low K-1-t bits are zero can have been reached.
   always_comb begin
      reach_next = '0;
      for (int s = 0; s < NS; s++) begin
         if (int'(sym_cnt) >= K - 1) begin
            reach_next[s] = 1'b1;
         end else begin
            reach_next[s] = ((s & ((1 << (K - 1 - int'(sym_cnt))) - 1)) == 0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_bm    <= '0;
         out_reach <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         sym_cnt   <= '0;
      end else if (refresh) begin
         // Drops any pending bundle and restarts the frame.
         out_valid <= 1'b0;
         out_bm    <= '0;
         out_reach <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         sym_cnt   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_bm    <= bm_next;
         out_reach <= reach_next;
         out_first <= (sym_cnt == '0);
         out_last  <= cnt_is_last;
         sym_cnt   <= cnt_is_last ? '0 : sym_cnt + CW'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_viterbi_bmu_param.sv
module tb_viterbi_bmu_param;

   localparam int K   = 3;
   localparam int FL  = 4;
   localparam int SW  = 3;
   localparam int NS  = 1 << (K - 1);
   localparam int NB  = 1 << K;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;
`ifdef VITERBI_BMU_SOFT_EN
   localparam int IW  = 2 * SW;
   localparam int BMW = SW + 1;
`else
   localparam int IW  = 2;
   localparam int BMW = 2;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              refresh;
   logic              in_valid;
   logic              in_ready;
   logic [IW-1:0]     in_sym;
   logic              out_valid;
   logic              out_ready;
   logic [NB*BMW-1:0] out_bm;
   logic [NS-1:0]     out_reach;
   logic              out_first;
   logic              out_last;

   int n_checks = 0;
   int n_fail   = 0;

   viterbi_bmu_param #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL), .SOFT_W(SW)) dut (
      .clk(clk), .rst(rst), .refresh(refresh),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
      .out_valid(out_valid), .out_ready(out_ready), .out_bm(out_bm),
      .out_reach(out_reach), .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int parity(input int v);
      int c = 0;
      for (int i = 0; i < 32; i++) c += (v >> i) & 1;
      return c % 2;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Encode every (state, input bit) pair and measure distance to the received pair.
   function automatic logic [NB*BMW-1:0] model_bm(input logic [IW-1:0] sym);
      logic [NB*BMW-1:0] res = '0;
      for (int s = 0; s < NS; s++) begin
         for (int b = 0; b < 2; b++) begin
            int reg_val = b * (1 << (K - 1)) + s;
            int e0 = parity(reg_val & int'(G0));
            int e1 = parity(reg_val & int'(G1));
            int bm;
`ifdef VITERBI_BMU_SOFT_EN
            int m  = (1 << SW) - 1;
            int r0 = int'(sym[IW-1:SW]);
            int r1 = int'(sym[SW-1:0]);
            bm = iabs(r0 - e0 * m) + iabs(r1 - e1 * m);
`else
            int c0 = int'(sym[1]);
            int c1 = int'(sym[0]);
            bm = ((c0 != e0) ? 1 : 0) + ((c1 != e1) ? 1 : 0);
`endif
            res[(s * 2 + b) * BMW +: BMW] = BMW'(bm);
         end
      end
      return res;
   endfunction

   // Set of states reachable after t steps of the encoder from state 0.
   function automatic logic [NS-1:0] model_reach(input int t);
      logic [NS-1:0] cur = 1;
      logic [NS-1:0] nxt;
      for (int i = 0; i < t; i++) begin
         nxt = '0;
         for (int s = 0; s < NS; s++)
            if (cur[s])
               for (int b = 0; b < 2; b++)
                  nxt[(b * (1 << (K - 1)) + s) >> 1] = 1'b1;
         cur = nxt;
      end
      return cur;
   endfunction

   bit                m_v     = 0;
   logic [NB*BMW-1:0] m_bm    = '0;
   logic [NS-1:0]     m_reach = '0;
   bit                m_first = 0;
   bit                m_last  = 0;
   int                m_t     = 0;

   always @(negedge clk) begin
      bit m_rdy;
      if (rst) begin
         m_v = 0; m_bm = '0; m_reach = '0; m_first = 0; m_last = 0; m_t = 0;
      end
      m_rdy = !refresh && (!m_v || out_ready);
      check("in_ready", in_ready, m_rdy);
      check("out_valid", out_valid, m_v);
      if (m_v) begin
         check("out_bm", out_bm, m_bm);
         check("out_reach", out_reach, m_reach);
         check("out_first", out_first, m_first);
         check("out_last", out_last, m_last);
      end
      if (!rst) begin
         if (refresh) begin
            m_v = 0; m_bm = '0; m_reach = '0; m_first = 0; m_last = 0; m_t = 0;
         end else if (in_valid && m_rdy) begin
            m_v     = 1;
            m_bm    = model_bm(in_sym);
            m_reach = model_reach(m_t);
            m_first = (m_t == 0);
            m_last  = (m_t == FL - 1);
            m_t     = (m_t + 1) % FL;
         end else if (out_ready) begin
            m_v = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input bit v, input bit r, input logic [IW-1:0] s, input bit rf);
      @(posedge clk);
      #1;
      in_valid  = v;
      out_ready = r;
      in_sym    = s;
      refresh   = rf;
   endtask

   function automatic logic [BMW-1:0] lane(input int j);
      return out_bm[j*BMW +: BMW];
   endfunction

   logic [11:0] tv = 12'b1101_1110_1011;
   logic [11:0] tr = 12'b1011_0110_1101;
   logic [23:0] ts = 24'b11_10_01_00_10_11_00_01_11_10_00_01;

   initial begin
      rst = 1'b1; refresh = 1'b0; in_valid = 1'b0; in_sym = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_bm", out_bm, 0);
      check("reset out_reach", out_reach, 0);

      // Refresh, then a single 00 symbol.
      step(0, 1, '0, 1);
      step(1, 1, IW'(2'b00), 0);
      step(0, 1, '0, 0);
      #1;
      check("t1 out_valid", out_valid, 1);
      check("t1 out_first", out_first, 1);
      check("t1 out_reach", out_reach, 4'b0001);
`ifndef VITERBI_BMU_SOFT_EN
      check("t1 bm s0b0", lane(0), 0);
      check("t1 bm s0b1", lane(1), 2);
      check("t1 bm s1b0", lane(2), 2);
      check("t1 bm s1b1", lane(3), 0);
`endif

      // Back-to-back 11, 10, 00 from a fresh frame.
      step(0, 1, '0, 1);
      step(1, 1, IW'(2'b11), 0);
      step(1, 1, IW'(2'b10), 0);
      #1;
      check("t2 reach sym0", out_reach, 4'b0001);
`ifndef VITERBI_BMU_SOFT_EN
      check("t2 bm s0b1", lane(1), 0);
      check("t2 bm s0b0", lane(0), 2);
`endif
      step(1, 1, IW'(2'b00), 0);
      #1 check("t2 reach sym1", out_reach, 4'b0101);
      step(0, 1, '0, 0);
      #1 check("t2 reach sym2", out_reach, 4'b1111);

      // Stall: out_ready low for 3 cycles with a symbol waiting; also frame wrap.
      step(1, 0, IW'(2'b01), 0);
      #1 check("t3 in_ready first", in_ready, 1);
      step(1, 0, IW'(2'b10), 0);
      #1;
      check("t3 in_ready stalled", in_ready, 0);
      check("t3 out_last", out_last, 1);
      step(1, 0, IW'(2'b10), 0);
      step(1, 0, IW'(2'b10), 0);
      #1 check("t3 in_ready still stalled", in_ready, 0);
      step(1, 1, IW'(2'b10), 0);
      #1 check("t3 in_ready released", in_ready, 1);
      step(0, 1, '0, 0);
      #1;
      check("t4 wrap out_first", out_first, 1);
      check("t4 wrap out_last", out_last, 0);
      check("t4 wrap out_reach", out_reach, 4'b0001);

      // Refresh mid-frame with a competing in_valid.
      step(1, 1, IW'(2'b01), 0);
      step(1, 1, IW'(2'b11), 1);
      #1 check("t5 in_ready during refresh", in_ready, 0);
      step(0, 1, '0, 0);
      #1;
      check("t5 refresh out_valid", out_valid, 0);
      check("t5 refresh out_bm", out_bm, 0);
      step(1, 1, IW'(2'b11), 0);
      step(0, 1, '0, 0);
      #1;
      check("t5 post-refresh first", out_first, 1);
      check("t5 post-refresh reach", out_reach, 4'b0001);

      // Asynchronous reset mid-frame at t=2 with a held bundle.
      step(1, 1, IW'(2'b00), 0);
      step(1, 1, IW'(2'b01), 0);
      step(0, 0, '0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b1; in_sym = IW'(2'b11);
      #1;
      check("t5 rst out_valid", out_valid, 0);
      check("t5 rst out_bm", out_bm, 0);
      check("t5 rst out_reach", out_reach, 0);
      check("t5 rst out_last", out_last, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 check("t5 rst not consumed", out_valid, 0);
      step(1, 1, IW'(2'b10), 0);
      step(0, 1, '0, 0);
      #1;
      check("t5 post-rst first", out_first, 1);
      check("t5 post-rst reach", out_reach, 4'b0001);

`ifdef VITERBI_BMU_SOFT_EN
      // Soft pair r0=7, r1=0.
      step(1, 1, {3'd7, 3'd0}, 0);
      step(0, 1, '0, 0);
      #1;
      check("t6 soft s0b0", lane(0), 7);
      check("t6 soft s2b0", lane(4), 0);
      check("t6 soft s2b1", lane(5), 14);
      check("t6 soft s3b1", lane(7), 0);
`endif

      // Mixed valid/ready pattern, checked by the model every cycle.
      for (int i = 0; i < 12; i++) begin
         step(tv[i], tr[i], IW'(ts[2*i +: 2]), 0);
      end
      step(0, 1, '0, 0);
      step(0, 1, '0, 0);
      @(posedge clk);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
